// File: rtl/timer_pkg.sv
// Shared constants for the BCD countdown timer: FSM state codes and digit limits.
package timer_pkg;

  localparam logic [1:0] ST_ENTRY = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] DIG_MAX  = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down counter: parallel load has priority over decrement,
// wrapping from 0 to max_val and raising borrow so the next digit can step.
module bcd_digit_down (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic [3:0] max_val,
  output logic [3:0] value,
  output logic       borrow
);

  logic [3:0] val_q;
  logic [3:0] val_d;

  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = load_val;
    end else if (en) begin
      val_d = (val_q == 4'd0) ? max_val : val_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= 4'd0;
    end else begin
      val_q <= val_d;
    end
  end

  assign value  = val_q;
  assign borrow = en & (val_q == 4'd0);

endmodule

// File: rtl/timer_countdown_bcd.sv
// M:SS countdown timer: keypad digits shift in while in entry mode, then the
// three chained BCD digits count down once per rising edge of CLK_1HZ.
module timer_countdown_bcd
  import timer_pkg::*;
(
  input  logic       CLK_100HZ,
  input  logic       RST_N,
  input  logic       EN_N,
  input  logic [3:0] D,
  input  logic       LOAD_N,
  input  logic       CLK_1HZ,
  output logic [3:0] MIN,
  output logic [3:0] SEC_TENS,
  output logic [3:0] SEC_ONES,
  output logic       ZERO,
  output logic       RUNNING,
  output logic       DONE
);

  logic       c1_q;
  logic [1:0] state_q, state_d;
  logic       done_q, done_d;
  logic       tick;
  logic       key_ok;
  logic       shift;
  logic       dec;
  logic       last_sec;
  logic       ones_borrow, tens_borrow, min_borrow_unused;
  logic [3:0] ones_val, tens_val, min_val;

  assign tick = CLK_1HZ & ~c1_q;

  // Keeping SEC_ONES <= 5 before the shift guarantees SEC_TENS stays 0-5.
  assign key_ok   = ~LOAD_N & (D <= DIG_MAX) & (ones_val <= TENS_MAX);
  assign shift    = (state_q == ST_ENTRY) & tick & key_ok;
  assign dec      = (state_q == ST_RUN) & EN_N & tick & ~ZERO;
  assign last_sec = (min_val == 4'd0) & (tens_val == 4'd0) & (ones_val == 4'd1);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        if (EN_N && !ZERO) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!EN_N) begin
          state_d = ST_ENTRY;
        end else if (dec && last_sec) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (!EN_N) state_d = ST_ENTRY;
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge CLK_100HZ or negedge RST_N) begin
    if (!RST_N) begin
      c1_q    <= 1'b1;
      state_q <= ST_ENTRY;
      done_q  <= 1'b0;
    end else begin
      c1_q    <= CLK_1HZ;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  bcd_digit_down u_ones (
    .clk      (CLK_100HZ),
    .rst_n    (RST_N),
    .load     (shift),
    .load_val (D),
    .en       (dec),
    .max_val  (DIG_MAX),
    .value    (ones_val),
    .borrow   (ones_borrow)
  );

  bcd_digit_down u_tens (
    .clk      (CLK_100HZ),
    .rst_n    (RST_N),
    .load     (shift),
    .load_val (ones_val),
    .en       (ones_borrow),
    .max_val  (TENS_MAX),
    .value    (tens_val),
    .borrow   (tens_borrow)
  );

  // Minutes never borrow out: the run state is left before 0:00 can be decremented.
  bcd_digit_down u_min (
    .clk      (CLK_100HZ),
    .rst_n    (RST_N),
    .load     (shift),
    .load_val (tens_val),
    .en       (tens_borrow),
    .max_val  (DIG_MAX),
    .value    (min_val),
    .borrow   (min_borrow_unused)
  );

  assign MIN      = min_val;
  assign SEC_TENS = tens_val;
  assign SEC_ONES = ones_val;
  assign ZERO     = (min_val == 4'd0) & (tens_val == 4'd0) & (ones_val == 4'd0);
  assign RUNNING  = (state_q == ST_RUN);
  assign DONE     = done_q;

endmodule

// File: doc/timer_countdown_bcd.md
# timer_countdown_bcd

Three-digit BCD countdown timer (M:SS, 0:00 to 9:59) for the microwave datapath, directly downstream of the keypad/timer input control stage. It consumes that stage's BCD digit D, load strobe LOAD_N and shared event line CLK_1HZ. In entry mode it shifts keyed digits into the display registers; in run mode it counts down once per second. It reports zero/done status to the main controller and drives the digit values to the display decoders.

## Interface
- No parameters.
- CLK_100HZ  input  1  system clock; all state changes on its rising edge
- RST_N  input  1  asynchronous, active-low reset
- EN_N  input  1  mode select, same signal as upstream: 0 = entry (keypad enabled), 1 = run (count down)
- D  input  4  BCD digit from the keypad encoder
- LOAD_N  input  1  active-low, digit valid while a key is held
- CLK_1HZ  input  1  upstream event line: debounced key clock in entry mode, 1 Hz square wave in run mode
- MIN  output  4  minutes digit, 0–9
- SEC_TENS  output  4  seconds tens digit, 0–5
- SEC_ONES  output  4  seconds ones digit, 0–9
- ZERO  output  1  1 when all three digits are 0
- RUNNING  output  1  1 while in ST_RUN
- DONE  output  1  one-cycle pulse when a countdown reaches 0:00

## Operation
- Clock and reset: one clock, CLK_100HZ; RST_N is asynchronous and active-low. All inputs are in the CLK_100HZ domain, so there are no synchronizers.
- Tick detection:
  - Register CLK_1HZ into c1_q, which resets to 1.
  - TICK = CLK_1HZ & ~c1_q, so TICK is one cycle per rising edge.
  - If CLK_1HZ is already high at reset release, no tick is produced.
- States: ST_ENTRY, ST_RUN, ST_DONE. Transitions are evaluated on the registered state.
  - ST_ENTRY:
    - On TICK & ~LOAD_N & D≤9, shift left: MIN←SEC_TENS, SEC_TENS←SEC_ONES, SEC_ONES←D. The old MIN is discarded.
    - The shift is rejected (all digits unchanged) if D>9 or if the current SEC_ONES>5, because SEC_TENS must stay in 0–5.
    - When EN_N=1: go to ST_RUN if the count is nonzero; otherwise stay in ST_ENTRY.
  - ST_RUN:
    - On TICK, decrement with BCD borrow. SEC_ONES 0→9 borrows from SEC_TENS; SEC_TENS 0→5 borrows from MIN.
    - If the decrement produces 0:00: go to ST_DONE and assert DONE for that cycle.
    - If EN_N=0 (pause/cancel): go to ST_ENTRY with the digits kept, and ignore the same-cycle TICK.
  - ST_DONE:
    - Digits hold at 0:00 and TICK is ignored.
    - EN_N=0 → ST_ENTRY.
- ZERO and RUNNING are combinational decodes of the registered digits and state.
- Values outside range are never produced; counting never goes below 0:00.

## Timing
- Reset values: MIN=SEC_TENS=SEC_ONES=0, ZERO=1, RUNNING=0, DONE=0, state ST_ENTRY, c1_q=1.
- Latency from the CLK_1HZ rising edge (cycle N, sampled) to updated digits: visible after edge N+1, i.e. one CLK_100HZ cycle.
- DONE is registered. It is high for exactly the cycle in which the digits first show 0:00, and RUNNING falls in that same cycle.
- Simultaneous events:
  - TICK in the same cycle as the EN_N 0→1 change: treated as an entry tick, since the state is still ST_ENTRY.
  - TICK in the same cycle as the EN_N 1→0 change in ST_RUN: no decrement.
- A held key (LOAD_N low across several cycles) shifts once per TICK, not once per cycle.
- RST_N assertion mid-countdown clears everything immediately (asynchronous). The first TICK after release needs a fresh 0→1 edge.

## Structure
- Shared package (timer_pkg): state encodings ST_ENTRY/ST_RUN/ST_DONE (2 bits), BCD limits DIG_MAX=9 and TENS_MAX=5.
- One sub-module, bcd_digit_down: a 4-bit down counter with load, enable, max-value input and borrow-out. Instantiate it three times and chain the borrows.
- Top-level contents: tick edge detector, FSM, entry shift/validation mux.

## Test plan
- Reset, then key 1,3,0 (EN_N=0, LOAD_N low, one CLK_1HZ edge each) → MIN=1, SEC_TENS=3, SEC_ONES=0, ZERO=0, RUNNING=0.
- From 1:30, set EN_N=1 and apply 3 edges → 1:27 after the third, with each update exactly one cycle after its edge; then 0:00→… check borrow sequences 1:00→0:59 and 0:10→0:09.
- From 0:02 in run, apply 2 edges → 0:01, then 0:00. DONE is high for one cycle, ZERO=1, state is ST_DONE. Further edges leave 0:00 unchanged.
- Entry with digits 0:07 then key 8 → the shift is rejected (SEC_ONES=7>5) and the display stays 0:07. Key D=4'hA → ignored.
- EN_N=1 with 0:00 → RUNNING stays 0 and there is no DONE pulse. During run at 2:15, drop EN_N with a same-cycle edge → ST_ENTRY with 2:15 held.
- Assert RST_N mid-count at 5:41 → all digits 0, ZERO=1 without waiting for a clock edge. Release with CLK_1HZ high → no tick until the next rising edge.
